// File: rtl/tron_pkg.sv
// Shared constants and the probe FSM state type for the trail-map probe block.
package tron_pkg;

  localparam int GRID_W_DEF = 160;
  localparam int GRID_H_DEF = 120;
  localparam int ADDR_W_DEF = 15;

  localparam logic [7:0] CELL_EMPTY = 8'h01;
  localparam logic [7:0] CELL_RED   = 8'h02;
  localparam logic [7:0] CELL_BLUE  = 8'h03;
  localparam logic [7:0] CELL_WALL  = 8'h04;

  localparam logic [7:0] OUT_SAFE    = 8'h01;
  localparam logic [7:0] OUT_COLLIDE = 8'h00;

  localparam logic [2:0] GS_PLAY = 3'd1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LATCH,
    ST_RD_R,
    ST_RD_B,
    ST_CHK,
    ST_WR_R,
    ST_WR_B,
    ST_DONE,
    ST_CLEAR
  } probe_state_t;

endpackage

// File: rtl/trail_probe_if.sv
// Single-port trail-map RAM bus: the probe is master, the RAM is slave.
interface trail_probe_if #(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/trail_addr_calc.sv
// Grid cell (x, y) to linear RAM address, plus out-of-bounds flag.
module trail_addr_calc #(
  parameter int GRID_W = 160,
  parameter int GRID_H = 120,
  parameter int ADDR_W = 15
) (
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              oob
);

  localparam logic [7:0] W_LIM = 8'(GRID_W);
  localparam logic [7:0] H_LIM = 8'(GRID_H);

  logic [ADDR_W-1:0] x_w;
  logic [ADDR_W-1:0] y_w;

  assign x_w = ADDR_W'(x);
  assign y_w = ADDR_W'(y);

  // y*160 as two shifts keeps this multiplier-free
  assign addr = (y_w << 7) + (y_w << 5) + x_w;
  assign oob  = (x >= W_LIM) || (y >= H_LIM);

endmodule

// File: rtl/trail_probe.sv
// Per-frame head-cell probe of the trail-map RAM, with a full-map clear sweep.
//   state | meaning
//   IDLE  | wait for frame edge in PLAY or clear_start
//   LATCH | capture head coordinates
//   RD_R  | present red address (read)
//   RD_B  | present blue address, capture red cell
//   CHK   | capture blue cell, resolve collisions
//   WR_R  | mark red trail unless red collided
//   WR_B  | mark blue trail unless blue collided
//   DONE  | publish results, pulse probe_done
//   CLEAR | sweep every cell to CELL_EMPTY
module trail_probe
  import tron_pkg::*;
#(
  parameter int GRID_W = 160,
  parameter int GRID_H = 120,
  parameter int ADDR_W = 15
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          frame_clk,
  input  logic [2:0]    Game_State,
  input  logic          clear_start,
  input  logic [7:0]    Red_X,
  input  logic [7:0]    Red_Y,
  input  logic [7:0]    Blue_X,
  input  logic [7:0]    Blue_Y,
  trail_probe_if.master mem,
  output logic [7:0]    red_color,
  output logic [7:0]    blue_color,
  output logic          busy,
  output logic          probe_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);

  probe_state_t      state, state_nxt;
  logic              frame_q;
  logic [7:0]        rx, ry, bx, by;
  logic [7:0]        red_cell;
  logic              red_col, blue_col;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] red_addr, blue_addr;
  logic              red_oob, blue_oob;
  logic              play, frame_rise, head_on, red_hit, blue_hit;

  trail_addr_calc #(.GRID_W(GRID_W), .GRID_H(GRID_H), .ADDR_W(ADDR_W)) u_calc_red (
    .x(rx), .y(ry), .addr(red_addr), .oob(red_oob)
  );

  trail_addr_calc #(.GRID_W(GRID_W), .GRID_H(GRID_H), .ADDR_W(ADDR_W)) u_calc_blue (
    .x(bx), .y(by), .addr(blue_addr), .oob(blue_oob)
  );

  assign play       = (Game_State == GS_PLAY);
  assign frame_rise = frame_clk & ~frame_q;
  assign head_on    = (rx == bx) && (ry == by);
  // oob forces a hit, so whatever the RAM returned for that bike is irrelevant
  assign red_hit    = red_oob | (red_cell != CELL_EMPTY) | head_on;
  assign blue_hit   = blue_oob | (mem.mem_rdata != CELL_EMPTY) | head_on;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mem.mem_addr  = '0;
    mem.mem_we    = 1'b0;
    mem.mem_wdata = 8'h00;
    busy          = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (clear_start)              state_nxt = ST_CLEAR;
        else if (frame_rise && play)  state_nxt = ST_LATCH;
      end
      ST_LATCH: state_nxt = ST_RD_R;
      ST_RD_R: begin
        if (!red_oob) mem.mem_addr = red_addr;
        state_nxt = ST_RD_B;
      end
      ST_RD_B: begin
        if (!blue_oob) mem.mem_addr = blue_addr;
        state_nxt = ST_CHK;
      end
      ST_CHK: state_nxt = ST_WR_R;
      ST_WR_R: begin
        if (!red_col) begin
          mem.mem_addr  = red_addr;
          mem.mem_we    = 1'b1;
          mem.mem_wdata = CELL_RED;
        end
        state_nxt = ST_WR_B;
      end
      ST_WR_B: begin
        if (!blue_col) begin
          mem.mem_addr  = blue_addr;
          mem.mem_we    = 1'b1;
          mem.mem_wdata = CELL_BLUE;
        end
        state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_CLEAR: begin
        mem.mem_addr  = clr_addr;
        mem.mem_we    = 1'b1;
        mem.mem_wdata = CELL_EMPTY;
        if (clr_addr == LAST_ADDR) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_q    <= 1'b0;
      rx         <= 8'h00;
      ry         <= 8'h00;
      bx         <= 8'h00;
      by         <= 8'h00;
      red_cell   <= 8'h00;
      red_col    <= 1'b0;
      blue_col   <= 1'b0;
      clr_addr   <= '0;
      red_color  <= OUT_SAFE;
      blue_color <= OUT_SAFE;
      probe_done <= 1'b0;
    end else begin
      frame_q    <= frame_clk;
      probe_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          clr_addr <= '0;
          if (!play) begin
            red_color  <= OUT_SAFE;
            blue_color <= OUT_SAFE;
          end
        end
        ST_LATCH: begin
          rx <= Red_X;
          ry <= Red_Y;
          bx <= Blue_X;
          by <= Blue_Y;
        end
        ST_RD_B: red_cell <= mem.mem_rdata;
        ST_CHK: begin
          red_col  <= red_hit;
          blue_col <= blue_hit;
        end
        ST_DONE: begin
          red_color  <= red_col  ? OUT_COLLIDE : OUT_SAFE;
          blue_color <= blue_col ? OUT_COLLIDE : OUT_SAFE;
          probe_done <= 1'b1;
        end
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_ADDR) begin
            red_color  <= OUT_SAFE;
            blue_color <= OUT_SAFE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
